// File: rtl/lsu_pkg.sv
// Shared definitions for the per-thread load-store unit: FSM state codes,
// core FSM handshake constants and the decoded operation select.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } lsu_state_t;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_ATOM  = 2'd3
  } lsu_op_t;

  // Decoded-enable priority: atomic beats store, store beats load.
  function automatic lsu_op_t op_select(input logic i_atomic, input logic i_write,
                                        input logic i_read);
    if (i_atomic)     return OP_ATOM;
    else if (i_write) return OP_STORE;
    else if (i_read)  return OP_LOAD;
    else              return OP_NONE;
  endfunction

endpackage

// File: rtl/lsu_watchdog.sv
// Loadable down-counter bounding how long one memory phase may wait.
// o_expired flags the last permitted wait cycle: if ready is still low on
// the coming edge, the phase is abandoned.
module lsu_watchdog #(
  parameter int LOAD_VALUE = 1,
  parameter int WIDTH      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  logic [WIDTH-1:0] r_count;

  // Reload on clear, count down one per stalled cycle, freeze when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (i_clear) begin
        r_count <= WIDTH'(LOAD_VALUE);
      end else if (i_count && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_expired = (r_count == WIDTH'(1));

endmodule

// File: rtl/lsu_atomic.sv
// Per-thread load-store unit: LDR, STR and ATOM (fetch-and-add) with an
// optional response watchdog. Every output is a register.
//
// Handshake: the LSU raises valid together with address (and write data) and
// holds all of them stable until ready is sampled high on a rising edge while
// in the matching WAIT state, or until the watchdog gives up. Ready seen in any
// other state is ignored.
module lsu_atomic
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_mem_read_enable,
  input  logic                 decoded_mem_write_enable,
  input  logic                 decoded_mem_atomic_enable,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready,
  output logic [2:0]           lsu_state,
  output logic [DATA_BITS-1:0] lsu_out,
  output logic                 lsu_error
);

  localparam int WD_BITS = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t           r_state, w_state_nxt;
  lsu_op_t              r_op, w_op_nxt, w_op_sel;
  logic                 r_rd_valid, w_rd_valid_nxt;
  logic [ADDR_BITS-1:0] r_rd_addr, w_rd_addr_nxt;
  logic                 r_wr_valid, w_wr_valid_nxt;
  logic [ADDR_BITS-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_BITS-1:0] r_wr_data, w_wr_data_nxt;
  logic [DATA_BITS-1:0] r_out, w_out_nxt;
  logic                 r_error, w_error_nxt;
  logic [ADDR_BITS-1:0] w_rs_addr;
  logic                 w_wd_clear, w_wd_count, w_wd_expired, w_timeout;

  // Address operand: low ADDR_BITS of rs, zero-extended when rs is narrower.
  generate
    if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
      assign w_rs_addr = rs[ADDR_BITS-1:0];
    end else begin : g_addr_ext
      assign w_rs_addr = {{(ADDR_BITS - DATA_BITS){1'b0}}, rs};
    end
  endgenerate

  assign w_op_sel  = op_select(decoded_mem_atomic_enable, decoded_mem_write_enable,
                               decoded_mem_read_enable);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && w_wd_expired;

  lsu_watchdog #(
    .LOAD_VALUE(TIMEOUT_CYCLES),
    .WIDTH     (WD_BITS)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .i_clear  (w_wd_clear),
    .i_count  (w_wd_count),
    .o_expired(w_wd_expired)
  );

  // Next-state and next-output logic; everything defaults to holding.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_addr_nxt  = r_rd_addr;
    w_wr_valid_nxt = r_wr_valid;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    w_out_nxt      = r_out;
    w_error_nxt    = r_error;
    w_wd_clear     = 1'b0;
    w_wd_count     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((core_state == CORE_REQUEST) && (w_op_sel != OP_NONE)) begin
          w_op_nxt    = w_op_sel;
          w_error_nxt = 1'b0;
          w_state_nxt = (w_op_sel == OP_STORE) ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        w_rd_valid_nxt = 1'b1;
        w_rd_addr_nxt  = w_rs_addr;
        w_wd_clear     = 1'b1;
        w_state_nxt    = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_read_ready) begin
          w_rd_valid_nxt = 1'b0;
          w_out_nxt      = mem_read_data;
          if (r_op == OP_ATOM) begin
            // The write targets the address already used for the read.
            w_wr_addr_nxt = r_rd_addr;
            w_wr_data_nxt = mem_read_data + rt;
            w_state_nxt   = ST_WR_REQ;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_timeout) begin
          w_rd_valid_nxt = 1'b0;
          w_error_nxt    = 1'b1;
          w_state_nxt    = ST_DONE;
        end else begin
          w_wd_count = 1'b1;
        end
      end
      ST_WR_REQ: begin
        w_wr_valid_nxt = 1'b1;
        if (r_op != OP_ATOM) begin
          w_wr_addr_nxt = w_rs_addr;
          w_wr_data_nxt = rt;
        end
        w_wd_clear  = 1'b1;
        w_state_nxt = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem_write_ready) begin
          w_wr_valid_nxt = 1'b0;
          w_state_nxt    = ST_DONE;
        end else if (w_timeout) begin
          w_wr_valid_nxt = 1'b0;
          w_error_nxt    = 1'b1;
          w_state_nxt    = ST_DONE;
        end else begin
          w_wd_count = 1'b1;
        end
      end
      ST_DONE: begin
        if (core_state == CORE_UPDATE) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over enable, enable low freezes all.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NONE;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_out      <= '0;
      r_error    <= 1'b0;
    end else if (enable) begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_out      <= w_out_nxt;
      r_error    <= w_error_nxt;
    end
  end

  assign mem_read_valid    = r_rd_valid;
  assign mem_read_address  = r_rd_addr;
  assign mem_write_valid   = r_wr_valid;
  assign mem_write_address = r_wr_addr;
  assign mem_write_data    = r_wr_data;
  assign lsu_state         = r_state;
  assign lsu_out           = r_out;
  assign lsu_error         = r_error;

endmodule
